// File: rtl/mem32x8_pkg.sv
// mem32x8_pkg: shared bus widths and master state encoding for the 32x8 master
// and its bidirectional memory.
package mem32x8_pkg;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_CAPTURE, ST_TURN} state_t;
endpackage

// File: rtl/mem32x8_mem.sv
// mem32x8_mem: single-port memory on a shared bidirectional data bus; writes on
// the clock edge, drives the bus combinationally while enabled for read.
module mem32x8_mem #(
   parameter int ADDR_W = mem32x8_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem32x8_pkg::DEF_DATA_W
) (
   input  logic              clk,
   input  logic              mem_en,
   input  logic              mem_rw,
   input  logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk)
      if (mem_en && mem_rw) r_mem[mem_addr] <= mem_data;

   assign mem_data = (mem_en && !mem_rw) ? r_mem[mem_addr] : 'z;
endmodule

// File: rtl/mem_master32x8.sv
// mem_master32x8: single-outstanding request master for a bidirectional-bus
// memory; reads take a turnaround cycle so the bus is idle before any write.
module mem_master32x8
   import mem32x8_pkg::*;
#(
   parameter int ADDR_W = mem32x8_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem32x8_pkg::DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data
);
   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_en;
   logic              r_rw;
   logic              r_valid;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_en    <= 1'b0;
         r_rw    <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE:
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_en    <= 1'b1;
                  r_rw    <= req_we;
                  r_state <= req_we ? ST_WRITE : ST_READ;
               end
            ST_WRITE: begin
               r_en    <= 1'b0;
               r_rw    <= 1'b0;
               r_state <= ST_IDLE;
            end
            ST_READ:
               r_state <= ST_CAPTURE;
            ST_CAPTURE: begin
               r_rdata <= mem_data;
               r_en    <= 1'b0;
               r_valid <= 1'b1;
               r_state <= ST_TURN;
            end
            ST_TURN: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
            default:
               r_state <= ST_IDLE;
         endcase
      end

   assign req_ready = (r_state == ST_IDLE) && rst_n;
   assign rsp_valid = r_valid;
   assign rsp_rdata = r_rdata;
   assign mem_en    = r_en;
   assign mem_rw    = r_rw;
   assign mem_addr  = r_addr;
   assign mem_data  = (r_state == ST_WRITE) ? r_wdata : 'z;
endmodule

// File: tb/tb_mem_master32x8.sv
// tb_mem_master32x8: master paired with the bidirectional memory, checked
// cycle by cycle against a transaction-level model of memory contents.
module tb_mem_master32x8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_we = 1'b0;
   logic [4:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   wire        req_ready, rsp_valid, mem_en, mem_rw;
   wire  [4:0] mem_addr;
   wire  [7:0] rsp_rdata;
   wire  [7:0] mem_data;

   int         errs = 0;
   int         checks = 0;
   logic [7:0] model [32];
   logic [7:0] last_rd = '0;

   always #5 clk = ~clk;

   mem_master32x8 dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   mem32x8_mem u_mem (
      .clk(clk), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // While busy, present a live-looking garbage request that must be ignored.
   task automatic junk();
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_addr  = 5'($urandom);
      req_wdata = 8'($urandom);
   endtask

   // Entered and left at a falling edge with the master idle.
   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      chk("wr_ready", req_ready, 1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      @(negedge clk);
      junk();
      chk("wr_en", mem_en, 1);
      chk("wr_rw", mem_rw, 1);
      chk("wr_addr", mem_addr, a);
      chk("wr_data", mem_data, d);
      chk("wr_busy", req_ready, 0);
      chk("wr_rsp", rsp_valid, 0);
      model[a] = d;
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_occupancy", req_ready, 1);
      chk("wr_idle_en", mem_en, 0);
      chk("wr_hold_addr", mem_addr, a);
   endtask

   task automatic rd(input logic [4:0] a);
      chk("rd_ready", req_ready, 1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'($urandom);
      @(negedge clk);
      junk();
      chk("rd_en", mem_en, 1);
      chk("rd_rw", mem_rw, 0);
      chk("rd_addr", mem_addr, a);
      chk("rd_busy", req_ready, 0);
      chk("rd_rsp", rsp_valid, 0);
      @(negedge clk);
      junk();
      chk("cap_en", mem_en, 1);
      chk("cap_rw", mem_rw, 0);
      chk("cap_data", mem_data, model[a]);
      chk("cap_busy", req_ready, 0);
      chk("cap_rsp", rsp_valid, 0);
      @(negedge clk);
      junk();
      chk("turn_en", mem_en, 0);
      chk("turn_rsp", rsp_valid, 1);
      chk("turn_rdata", rsp_rdata, model[a]);
      chk("turn_busy", req_ready, 0);
      last_rd = model[a];
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_occupancy", req_ready, 1);
      chk("rd_pulse_end", rsp_valid, 0);
      chk("rd_hold_rdata", rsp_rdata, last_rd);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_en", mem_en, 0);
      chk("rst_rw", mem_rw, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rdata", rsp_rdata, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);
      wr(5'd1, 8'h02);
      rd(5'd1);
      wr(5'd2, 8'hA5);
      wr(5'd31, 8'h5A);
      rd(5'd31);
      rd(5'd2);
      rd(5'd2);
      wr(5'd2, 8'h3C);
      rd(5'd2);
      for (int i = 0; i < 32; i++) wr(5'(i), 8'($urandom));
      for (int i = 0; i < 40; i++)
         if ($urandom_range(1, 0) == 1) wr(5'($urandom), 8'($urandom));
         else rd(5'($urandom));
      // Abort a read during its capture cycle.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
      @(negedge clk);
      junk();
      @(negedge clk);
      chk("abort_in_capture", mem_en, 1);
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("abort_en", mem_en, 0);
      chk("abort_ready", req_ready, 0);
      chk("abort_rsp", rsp_valid, 0);
      chk("abort_rdata", rsp_rdata, 0);
      chk("abort_addr", mem_addr, 0);
      last_rd = '0;
      @(negedge clk);
      chk("abort_rsp_held", rsp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_no_pulse", rsp_valid, 0);
      chk("abort_ready_back", req_ready, 1);
      rd(5'd7);
      for (int i = 0; i < 32; i++) rd(5'(i));
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
